// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, controller states
// and the per-operand forwarding priority rule.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } hz_state_e;

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w
    );
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
        if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding-select generation for both EX operand muxes.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_m,
    input  logic       i_regwrite_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_regwrite_w,
    output logic [1:0] o_fwd_a_e,
    output logic [1:0] o_fwd_b_e
);

    assign o_fwd_a_e = fwd_select(i_rs1_e, i_regwrite_m, i_rd_m, i_regwrite_w, i_rd_w);
    assign o_fwd_b_e = fwd_select(i_rs2_e, i_regwrite_m, i_rd_m, i_regwrite_w, i_rd_w);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush/freeze priority,
// data-memory wait tracking with a sticky timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rs1_e,
    input  logic [4:0]       i_rs2_e,
    input  logic [4:0]       i_rd_e,
    input  logic             i_memread_e,
    input  logic [4:0]       i_rd_m,
    input  logic             i_regwrite_m,
    input  logic [4:0]       i_rd_w,
    input  logic             i_regwrite_w,
    input  logic             i_redirect_e,
    input  logic             i_dmem_req_m,
    input  logic             i_dmem_ready,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_freeze_em,
    output logic [1:0]       o_fwd_a_e,
    output logic [1:0]       o_fwd_b_e,
    output logic             o_mem_timeout_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic [WCNT_W-1:0]  w_wait_cnt_nxt;
    logic               r_err;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_load_use;
    logic               w_mem_wait;
    logic               w_frozen;
    logic               w_stall_f;
    logic               w_stall_d;
    logic               w_flush_d;
    logic               w_flush_e;
    logic               w_freeze_em;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;

    forward_unit u_forward_unit (
        .i_rs1_e      (i_rs1_e),
        .i_rs2_e      (i_rs2_e),
        .i_rd_m       (i_rd_m),
        .i_regwrite_m (i_regwrite_m),
        .i_rd_w       (i_rd_w),
        .i_regwrite_w (i_regwrite_w),
        .o_fwd_a_e    (w_fwd_a),
        .o_fwd_b_e    (w_fwd_b)
    );

    assign w_load_use = i_memread_e && (i_rd_e != 5'd0) &&
                        ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
    assign w_mem_wait = i_dmem_req_m && !i_dmem_ready;
    assign w_frozen   = w_mem_wait || (r_state == ERR);

    // Control priority: freeze beats redirect beats load-use bubble.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_freeze_em = 1'b0;
        if (w_frozen) begin
            w_stall_f   = 1'b1;
            w_stall_d   = 1'b1;
            w_freeze_em = 1'b1;
        end else if (i_redirect_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = WCNT_W'(1);
                end
            end
            WAIT: begin
                if (!w_mem_wait) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WCNT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt = ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                end
            end
            ERR: w_state_nxt = ERR;
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_state_nxt == ERR) r_err <= 1'b1;
            if (w_stall_d && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Combinational outputs are held quiet for the whole time reset is asserted.
    assign o_stall_f         = w_stall_f   && !rst;
    assign o_stall_d         = w_stall_d   && !rst;
    assign o_flush_d         = w_flush_d   && !rst;
    assign o_flush_e         = w_flush_e   && !rst;
    assign o_freeze_em       = w_freeze_em && !rst;
    assign o_fwd_a_e         = rst ? 2'b00 : w_fwd_a;
    assign o_fwd_b_e         = rst ? 2'b00 : w_fwd_b;
    assign o_mem_timeout_err = r_err;
    assign o_stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand-written multi-cycle
// sequences, and randomized traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MT    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          memread_e, regwrite_m, regwrite_w, redirect_e, dmem_req_m, dmem_ready;
    logic          stall_f, stall_d, flush_d, flush_e, freeze_em, mem_timeout_err;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_rs1_d           (rs1_d),
        .i_rs2_d           (rs2_d),
        .i_rs1_e           (rs1_e),
        .i_rs2_e           (rs2_e),
        .i_rd_e            (rd_e),
        .i_memread_e       (memread_e),
        .i_rd_m            (rd_m),
        .i_regwrite_m      (regwrite_m),
        .i_rd_w            (rd_w),
        .i_regwrite_w      (regwrite_w),
        .i_redirect_e      (redirect_e),
        .i_dmem_req_m      (dmem_req_m),
        .i_dmem_ready      (dmem_ready),
        .o_stall_f         (stall_f),
        .o_stall_d         (stall_d),
        .o_flush_d         (flush_d),
        .o_flush_e         (flush_e),
        .o_freeze_em       (freeze_em),
        .o_fwd_a_e         (fwd_a_e),
        .o_fwd_b_e         (fwd_b_e),
        .o_mem_timeout_err (mem_timeout_err),
        .o_stall_cnt       (stall_cnt)
    );

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       memread_e;
        logic [4:0] rd_m;
        logic       regwrite_m;
        logic [4:0] rd_w;
        logic       regwrite_w, redirect_e, dmem_req_m, dmem_ready;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [4:0] ctl;   // {stall_f, stall_d, flush_d, flush_e, freeze_em}
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    localparam logic [4:0] C_IDLE   = 5'b00000;
    localparam logic [4:0] C_FROZEN = 5'b11001;
    localparam logic [4:0] C_REDIR  = 5'b00110;
    localparam logic [4:0] C_BUBBLE = 5'b11010;

    int    n_cmp  = 0;
    int    n_fail = 0;
    stim_t cur;
    bit    m_err;
    int    m_waits;
    int    m_cnt;
    vec_t  tab[10];

    function automatic stim_t st(input int r1d, r2d, r1e, r2e, rde, mr, rdm, wm, rdw, ww, rdr, req, rdy);
        stim_t s;
        s.rs1_d = 5'(r1d); s.rs2_d = 5'(r2d); s.rs1_e = 5'(r1e); s.rs2_e = 5'(r2e);
        s.rd_e = 5'(rde); s.memread_e = 1'(mr); s.rd_m = 5'(rdm); s.regwrite_m = 1'(wm);
        s.rd_w = 5'(rdw); s.regwrite_w = 1'(ww); s.redirect_e = 1'(rdr);
        s.dmem_req_m = 1'(req); s.dmem_ready = 1'(rdy);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        cur = s;
        rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e; rd_e = s.rd_e;
        memread_e = s.memread_e; rd_m = s.rd_m; regwrite_m = s.regwrite_m; rd_w = s.rd_w;
        regwrite_w = s.regwrite_w; redirect_e = s.redirect_e;
        dmem_req_m = s.dmem_req_m; dmem_ready = s.dmem_ready;
    endtask

    // Reference model: outputs straight from the hazard rules; state kept as a count of
    // consecutive waiting cycles plus a sticky error bit.
    function automatic logic [4:0] model_ctl(input stim_t s, input bit err);
        bit lu;
        lu = s.memread_e && (s.rd_e != 0) && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
        if ((s.dmem_req_m && !s.dmem_ready) || err) return C_FROZEN;
        if (s.redirect_e) return C_REDIR;
        if (lu) return C_BUBBLE;
        return C_IDLE;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs, input stim_t s);
        if (s.regwrite_m && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
        if (s.regwrite_w && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle with the current inputs: compare mid-cycle, then advance the model.
    task automatic step(input string nm, input logic [4:0] ectl, input logic [1:0] efa, input logic [1:0] efb);
        logic [4:0] mc;
        if (rst) begin
            m_err = 0; m_waits = 0; m_cnt = 0;
            ectl = 5'b0; efa = 2'b0; efb = 2'b0;
        end
        #4;
        check({nm, ".ctl"}, 32'({stall_f, stall_d, flush_d, flush_e, freeze_em}), 32'(ectl));
        check({nm, ".fa"}, 32'(fwd_a_e), 32'(efa));
        check({nm, ".fb"}, 32'(fwd_b_e), 32'(efb));
        check({nm, ".err"}, 32'(mem_timeout_err), 32'(m_err));
        check({nm, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_err = 0; m_waits = 0; m_cnt = 0;
        end else begin
            mc = model_ctl(cur, m_err);
            if (mc[3] && m_cnt < CMAX) m_cnt++;
            if (!m_err) begin
                if (cur.dmem_req_m && !cur.dmem_ready) begin
                    m_waits++;
                    if (m_waits > MT) m_err = 1;
                end else begin
                    m_waits = 0;
                end
            end
        end
        #1;
    endtask

    task automatic step_model(input string nm);
        step(nm, model_ctl(cur, m_err), model_fwd(cur.rs1_e, cur), model_fwd(cur.rs2_e, cur));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_model("reset");
        rst = 1'b0;
    endtask

    initial begin
        // Table of single-cycle vectors, all from the RUN state.
        //                    r1d r2d r1e r2e rde mr rdm wm rdw ww rdr req rdy
        tab[0] = '{"idle",     st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_IDLE,   2'b00, 2'b00};
        tab[1] = '{"lu_rs2",   st(1, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0), C_BUBBLE, 2'b00, 2'b00};
        tab[2] = '{"lu_x0",    st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), C_IDLE,   2'b00, 2'b00};
        tab[3] = '{"no_load",  st(3, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0), C_IDLE,   2'b00, 2'b00};
        tab[4] = '{"fwd_both", st(0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0), C_IDLE,   2'b10, 2'b00};
        tab[5] = '{"fwd_wb",   st(0, 0, 7, 7, 0, 0, 0, 1, 7, 1, 0, 0, 0), C_IDLE,   2'b01, 2'b01};
        tab[6] = '{"fwd_nowr", st(0, 0, 4, 6, 0, 0, 4, 0, 6, 1, 0, 1, 1), C_IDLE,   2'b00, 2'b01};
        tab[7] = '{"redir",    st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_REDIR,  2'b00, 2'b00};
        tab[8] = '{"redir_lu", st(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0), C_REDIR,  2'b00, 2'b00};
        tab[9] = '{"wait_lu",  st(5, 0, 2, 0, 5, 1, 2, 1, 0, 0, 1, 1, 0), C_FROZEN, 2'b10, 2'b00};

        drive(st(5, 5, 7, 7, 5, 1, 7, 1, 7, 1, 1, 1, 0));
        rst = 1'b1;
        @(posedge clk); #1;
        step("rst_forced", C_IDLE, 2'b00, 2'b00);
        rst = 1'b0;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("after_rst", C_IDLE, 2'b00, 2'b00);

        // Load-use: one bubble, then quiet, counter at 1.
        drive(st(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        step("lu_bubble", C_BUBBLE, 2'b00, 2'b00);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("lu_after", C_IDLE, 2'b00, 2'b00);
        check("lu_cnt", 32'(stall_cnt), 32'd1);

        for (int i = 0; i < 10; i++) begin
            drive(tab[i].s);
            step(tab[i].name, tab[i].ctl, tab[i].fa, tab[i].fb);
        end

        // Three-cycle memory wait, redirect in the middle is ignored, then release.
        for (int i = 0; i < 3; i++) begin
            drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 1) ? 1 : 0, 1, 0));
            step("wait3", C_FROZEN, 2'b00, 2'b00);
        end
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step("wait3_done", C_IDLE, 2'b00, 2'b00);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step("wait3_redir", C_REDIR, 2'b00, 2'b00);

        // Single-cycle wait gives exactly one frozen cycle.
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step("wait1", C_FROZEN, 2'b00, 2'b00);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step("wait1_done", C_IDLE, 2'b00, 2'b00);

        // Timeout: MT+1 consecutive waits reach ERR; ERR holds the freeze.
        for (int i = 0; i <= MT; i++) begin
            drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            step("to_wait", C_FROZEN, 2'b00, 2'b00);
        end
        check("to_err_set", 32'(mem_timeout_err), 32'd1);
        drive(st(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0));
        step("err_frozen", C_FROZEN, 2'b00, 2'b00);
        step("err_frozen2", C_FROZEN, 2'b00, 2'b00);
        rst = 1'b1;
        step("err_rst", C_IDLE, 2'b00, 2'b00);
        rst = 1'b0;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("err_cleared", C_IDLE, 2'b00, 2'b00);
        check("err_clr_flag", 32'(mem_timeout_err), 32'd0);

        // Reset in the middle of a wait returns to RUN with a fresh wait budget.
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step_model("midwait");
        step_model("midwait");
        do_reset();
        for (int i = 0; i < MT; i++) step("midwait_fresh", C_FROZEN, 2'b00, 2'b00);
        check("midwait_noerr", 32'(mem_timeout_err), 32'd0);
        do_reset();

        // Counter saturation: 2^CW+2 load-use cycles.
        drive(st(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < (1 << CW) + 2; i++) step("sat", C_BUBBLE, 2'b00, 2'b00);
        check("sat_cnt", 32'(stall_cnt), 32'(CMAX));

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            s.rs1_d = 5'($urandom_range(0, 3)); s.rs2_d = 5'($urandom_range(0, 3));
            s.rs1_e = 5'($urandom_range(0, 3)); s.rs2_e = 5'($urandom_range(0, 3));
            s.rd_e = 5'($urandom_range(0, 3)); s.memread_e = 1'($urandom_range(0, 1));
            s.rd_m = 5'($urandom_range(0, 3)); s.regwrite_m = 1'($urandom_range(0, 1));
            s.rd_w = 5'($urandom_range(0, 3)); s.regwrite_w = 1'($urandom_range(0, 1));
            s.redirect_e = ($urandom_range(0, 3) == 0);
            s.dmem_req_m = 1'($urandom_range(0, 1));
            s.dmem_ready = (i % 200 > 150) ? 1'b0 : ($urandom_range(0, 2) != 0);
            drive(s);
            rst = ($urandom_range(0, 79) == 0);
            step_model("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives stall/flush of the IF/ID and ID/EX registers and the freeze of EX/MEM; produces forwarding selects for the EX operand muxes.
- Inserts load-use bubbles and squashes wrong-path instructions on redirect.
- Freezes the whole pipeline while the data memory is not ready; sticky timeout error on a hung memory.

Parameters:
MEM_TIMEOUT, 15, max consecutive wait cycles tolerated before entering ERR
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
rs1_d  in  5  rs1 of instruction in ID
rs2_d  in  5  rs2 of instruction in ID
rs1_e  in  5  rs1 of instruction in EX
rs2_e  in  5  rs2 of instruction in EX
rd_e  in  5  destination of instruction in EX
memread_e  in  1  EX instruction is a load
rd_m  in  5  destination in MEM
regwrite_m  in  1  MEM instruction writes the register file
rd_w  in  5  destination in WB
regwrite_w  in  1  WB instruction writes the register file
redirect_e  in  1  taken branch / jal / jalr resolved in EX
dmem_req_m  in  1  MEM stage issues a load/store this cycle
dmem_ready  in  1  data memory completes the request this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX (bubble)
freeze_em  out  1  hold ID/EX and EX/MEM
fwd_a_e  out  2  operand A select
fwd_b_e  out  2  operand B select
mem_timeout_err  out  1  sticky hung-memory flag
stall_cnt  out  CNT_W  saturating count of stall_d cycles

Behaviour:
- Interface: clock clk; reset rst, asynchronous, active-high.
- Reset values:
  - state=RUN, wait_cnt=0, mem_timeout_err=0, stall_cnt=0.
  - While rst is high, all combinational outputs are forced to 0.
- Forwarding (combinational, evaluated per operand; shown for A):
  - FWD_MEM (2'b10) if regwrite_m && rd_m!=0 && rd_m==rs1_e.
  - Otherwise FWD_WB (2'b01) if regwrite_w && rd_w!=0 && rd_w==rs1_e.
  - Otherwise FWD_NONE (2'b00). MEM has priority over WB.
- Terms:
  - load_use = memread_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
  - mem_wait = dmem_req_m && !dmem_ready.
- Priority, evaluated each cycle (first match wins):
  1. Frozen (mem_wait, or state==ERR): stall_f=stall_d=freeze_em=1, flush_d=flush_e=0. Forwarding selects still computed.
  2. redirect_e: flush_d=flush_e=1, stall_f=stall_d=0, so the PC loads the target. A simultaneous load_use is discarded.
  3. load_use: stall_f=stall_d=1, flush_e=1, flush_d=0. Exactly one bubble per load-use pair.
  4. Otherwise all control outputs are 0.
- FSM, registered:
  - RUN -> WAIT when mem_wait; wait_cnt <= 1.
  - WAIT -> RUN when dmem_ready (or dmem_req_m drops); wait_cnt <= 0.
  - WAIT stays in WAIT on mem_wait: wait_cnt++. When wait_cnt==MEM_TIMEOUT and still mem_wait -> ERR.
  - ERR: absorbing until rst; mem_timeout_err=1 registered from the ERR entry edge.
- The freeze is combinational in the same cycle ready is low. A 1-cycle wait causes exactly one frozen cycle.
- stall_cnt increments on every cycle with stall_d=1, including frozen cycles. It saturates at all-ones, no wrap.
- rst mid-WAIT returns to RUN immediately and clears the counters.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e enum {FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - hz_state_e enum {RUN, WAIT, ERR}.
- One sub-module, forward_unit: purely combinational, instantiated once; outputs fwd_a_e and fwd_b_e.
- FSM, priority logic and counters stay in the top module.

Test Plan:
1. Load-use: memread_e=1, rd_e=5, rs1_d=5 -> one cycle of stall_f=stall_d=flush_e=1; next cycle all 0; stall_cnt=1.
2. Double forward: rd_m=rd_w=7, both regwrite, rs1_e=7 -> fwd_a_e=2'b10. rd_m=0, rs2_e=0 -> fwd_b_e=2'b00.
3. Redirect with load_use in the same cycle -> flush_d=flush_e=1, stall_f=0.
4. dmem_req_m=1, dmem_ready low for 3 cycles -> freeze_em=1 for exactly 3 cycles, state WAIT, back to RUN; redirect_e during the freeze is ignored.
5. With MEM_TIMEOUT=4, ready held low -> ERR, mem_timeout_err=1, pipeline stays frozen; rst mid-ERR clears to RUN with all outputs 0.
6. Hold load_use for 2^CNT_W+2 cycles (CNT_W=4) -> stall_cnt saturates at 15.
